// File: rtl/seq_pkg.sv
// Shared constants for the 11011 sync-word serial link: sync word, FSM
// state encoding and the even-parity helper used by the transmitter.
package seq_pkg;

    // Sync word, sent MSB-first; the detector on the far end uses the same pair.
    localparam int                SYNC_W = 5;
    localparam logic [SYNC_W-1:0] SYNC   = 5'b11011;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_PAR  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_SYNC = ST_SYNC,
        S_DATA = ST_DATA,
        S_PAR  = ST_PAR,
        S_GAP  = ST_GAP
    } state_t;

    // Widest payload the parity helper accepts; callers zero-extend.
    localparam int PAR_MAX_W = 64;

    // Even-parity bit: makes the total number of ones (payload + bit) even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register. Load wins over shift; the
// vacated LSB fills with 0. Width must be at least 2.
module seq_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         sh,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sreg;

    // Shift register: reset clears, load captures, shift moves toward MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (ld) begin
            sreg <= din;
        end else if (sh) begin
            sreg <= {sreg[W-2:0], 1'b0};
        end
    end

    assign msb = sreg[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word, payload MSB-first, optional even
// parity, then an idle gap. All line outputs are registered.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line at 0, ready high, waiting for load
// SYNC   | sync word bit on the line (cnt = bits left after this one)
// DATA   | payload bit on the line (cnt = bits left after this one)
// PAR    | even-parity bit on the line (last frame bit)
// GAP    | forced idle-0 cycles after a frame (cnt = cycles left)
//
// The state register names what is currently on the line, so every output
// is computed one cycle ahead from the next-state logic.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_MAX = (MAX_SD > GAP_CYCLES) ? MAX_SD : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic             PAR_ON    = (PARITY_EN != 0);
    localparam logic             GAP_ON    = (GAP_CYCLES != 0);

    // The first sync bit leaves straight from IDLE, so the sync shifter is
    // preloaded with the remaining bits already aligned to its MSB.
    localparam logic [SYNC_W-1:0] SYNC_REST = {SYNC[SYNC_W-2:0], 1'b0};

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               out_nxt, out_valid_nxt, frame_done_nxt;
    logic               par_q, par_ld;
    logic               data_ld, data_sh, data_msb;
    logic               sync_ld, sync_sh, sync_msb;
    logic [PAR_MAX_W-1:0] par_arg;

    assign ready = (state == S_IDLE) && !rst;

    seq_piso #(.W(DATA_W)) u_data_piso (
        .clk (clk),
        .rst (rst),
        .ld  (data_ld),
        .sh  (data_sh),
        .din (data_in),
        .msb (data_msb)
    );

    seq_piso #(.W(SYNC_W)) u_sync_piso (
        .clk (clk),
        .rst (rst),
        .ld  (sync_ld),
        .sh  (sync_sh),
        .din (SYNC_REST),
        .msb (sync_msb)
    );

    // Zero-extend the payload for the shared parity helper.
    always_comb begin
        par_arg              = '0;
        par_arg[DATA_W-1:0]  = data_in;
    end

    // Next-state, counter and next line values.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        out_nxt        = 1'b0;
        out_valid_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        data_ld        = 1'b0;
        data_sh        = 1'b0;
        sync_ld        = 1'b0;
        sync_sh        = 1'b0;
        par_ld         = 1'b0;
        case (state)
            S_IDLE: begin
                if (load && ready) begin
                    state_nxt     = S_SYNC;
                    cnt_nxt       = SYNC_LAST;
                    out_nxt       = SYNC[SYNC_W-1];
                    out_valid_nxt = 1'b1;
                    data_ld       = 1'b1;
                    sync_ld       = 1'b1;
                    par_ld        = 1'b1;
                end
            end
            S_SYNC: begin
                out_valid_nxt = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                    out_nxt = sync_msb;
                    sync_sh = 1'b1;
                end else begin
                    state_nxt = S_DATA;
                    cnt_nxt   = DATA_LAST;
                    out_nxt   = data_msb;
                    data_sh   = 1'b1;
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_nxt        = cnt - CNT_ONE;
                    out_nxt        = data_msb;
                    out_valid_nxt  = 1'b1;
                    data_sh        = 1'b1;
                    frame_done_nxt = !PAR_ON && (cnt == CNT_ONE);
                end else if (PAR_ON) begin
                    state_nxt      = S_PAR;
                    out_nxt        = par_q;
                    out_valid_nxt  = 1'b1;
                    frame_done_nxt = 1'b1;
                end else if (GAP_ON) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = GAP_LAST;
                end else begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            S_PAR: begin
                if (GAP_ON) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = GAP_LAST;
                end else begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            S_GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, parity latch and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            out        <= out_nxt;
            out_valid  <= out_valid_nxt;
            frame_done <= frame_done_nxt;
            if (par_ld) begin
                par_q <= even_parity(par_arg);
            end
        end
    end

endmodule
